// File: rtl/usb_tx_pkg.sv
// Shared types and defaults for the USB TX feeder and its FIFO.
package usb_tx_pkg;

  // Transmit sequencer states.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SYNC     = 3'd1,
    WAIT_RDY = 3'd2,
    LOAD     = 3'd3,
    HOLD     = 3'd4,
    GAP      = 3'd5
  } tx_state_e;

  // One buffered byte, tagged with its end-of-packet marker.
  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } tx_entry_t;

  localparam int IPG_DEFAULT   = 4;
  localparam int DEPTH_DEFAULT = 16;

endpackage

// File: rtl/usb_sync_fifo.sv
// Single-clock FIFO with push/pop/flush and a combinational head read.
// Push when full and pop when empty are ignored. Flush and reset both
// empty the FIFO on the next edge and take priority over push/pop.
module usb_sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; simultaneous push and pop keep count.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents are don't-care once the pointers are cleared.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/usb_tx_feeder.sv
// Host-side TX packet stager feeding the USB core's transmit port.
// Bytes are buffered until a whole packet (wr_last seen) is present, then
// the core sequence is run: cs1_l low, a SYNC pulse, and one tx_load per
// tx_ready_ld, followed by an inter-packet gap with cs1_l high.
//
// Host handshake: a byte transfers on any rising edge where wr_valid and
// wr_ready are both high; wr_data/wr_last must be stable while wr_valid is
// high, and wr_ready never depends on wr_valid.
module usb_tx_feeder
  import usb_tx_pkg::*;
#(
  parameter int DEPTH      = DEPTH_DEFAULT,
  parameter int IPG_CYCLES = IPG_DEFAULT
) (
  input  logic                       gclk,
  input  logic                       reset,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [7:0]                 wr_data,
  input  logic                       wr_last,
  output logic                       cs1_l,
  output logic                       syn_gen_ld,
  output logic                       tx_load,
  output logic [7:0]                 tx_data,
  output logic                       tx_last_byte,
  input  logic                       tx_ready_ld,
  output logic                       busy,
  output logic [$clog2(DEPTH):0]     pkt_pending,
  output logic                       err_oversize,
  output tx_state_e                  state_dbg
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int GW = $clog2(IPG_CYCLES + 1) + 1;

  tx_state_e     state;
  logic [GW-1:0] gap_cnt;
  tx_entry_t     wr_entry;
  tx_entry_t     head;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push_fire;
  logic          pop;
  logic          oversize;
  logic          pkt_inc;
  logic          pkt_dec;

  assign wr_ready  = !fifo_full && !reset;
  assign push_fire = wr_valid && wr_ready;
  assign wr_entry  = '{last: wr_last, data: wr_data};
  assign pop       = (state == LOAD) && !fifo_empty;

  // A full FIFO with no complete packet can never drain: flush it.
  assign oversize  = fifo_full && (pkt_pending == '0);

  assign pkt_inc   = push_fire && wr_last;
  assign pkt_dec   = tx_load && tx_last_byte;

  assign busy      = (state != IDLE);
  assign state_dbg = state;

  usb_sync_fifo #(
    .WIDTH ($bits(tx_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (gclk),
    .reset (reset),
    .push  (push_fire),
    .wdata (wr_entry),
    .pop   (pop),
    .flush (oversize),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Complete-packet counter and the sticky oversize flag.
  always_ff @(posedge gclk) begin
    if (reset) begin
      pkt_pending  <= '0;
      err_oversize <= 1'b0;
    end else begin
      if (oversize) err_oversize <= 1'b1;
      case ({pkt_inc, pkt_dec})
        2'b10:   pkt_pending <= pkt_pending + CW'(1);
        2'b01:   pkt_pending <= pkt_pending - CW'(1);
        default: pkt_pending <= pkt_pending;
      endcase
    end
  end

  // Transmit sequencer; every core-side output is set together with the
  // state it belongs to, so all of them are registered.
  always_ff @(posedge gclk) begin
    if (reset) begin
      state        <= IDLE;
      cs1_l        <= 1'b1;
      syn_gen_ld   <= 1'b0;
      tx_load      <= 1'b0;
      tx_data      <= 8'h00;
      tx_last_byte <= 1'b0;
      gap_cnt      <= '0;
    end else begin
      syn_gen_ld <= 1'b0;
      tx_load    <= 1'b0;
      case (state)
        IDLE: begin
          if (pkt_pending != '0) begin
            state      <= SYNC;
            cs1_l      <= 1'b0;
            syn_gen_ld <= 1'b1;
          end
        end
        SYNC: begin
          state <= WAIT_RDY;
        end
        WAIT_RDY: begin
          if (tx_ready_ld) begin
            state        <= LOAD;
            tx_load      <= 1'b1;
            tx_data      <= head.data;
            tx_last_byte <= head.last;
          end
        end
        LOAD: begin
          if (tx_last_byte) begin
            state   <= GAP;
            cs1_l   <= 1'b1;
            gap_cnt <= GW'(1);
          end else begin
            state <= HOLD;
          end
        end
        HOLD: begin
          // Core drops tx_ready_ld one cycle after a load; skip that cycle.
          state <= WAIT_RDY;
        end
        GAP: begin
          // The IDLE cycle that follows is the last cycle of the gap.
          if (gap_cnt >= GW'(IPG_CYCLES - 1)) begin
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
        default: begin
          state <= IDLE;
          cs1_l <= 1'b1;
        end
      endcase
    end
  end

endmodule
